// File: rtl/vpu_lane_seq.sv
// Single-lane issue sequencer: collects per-slot operands, fires one start
// pulse to the lane, waits (bounded) for completion and returns the result.
module vpu_lane_seq #(
    parameter int OPERAND_WIDTH = 32,
    parameter int SRC_CNT       = 3,
    parameter int OP_WIDTH      = 16,
    parameter int TIMEOUT       = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [OP_WIDTH-1:0]              req_op_i,
    input  logic [1:0]                       req_src_cnt_i,
    input  logic [SRC_CNT*OPERAND_WIDTH-1:0] opnd_i,
    input  logic [SRC_CNT-1:0]               opnd_valid_i,
    output logic                             lane_start_o,
    output logic [OP_WIDTH-1:0]              lane_op_o,
    output logic [SRC_CNT*OPERAND_WIDTH-1:0] lane_operand_o,
    input  logic                             lane_done_i,
    input  logic [OPERAND_WIDTH-1:0]         lane_dout_i,
    output logic                             rsp_valid_o,
    input  logic                             rsp_ready_i,
    output logic [OPERAND_WIDTH-1:0]         rsp_data_o,
    output logic                             rsp_err_o
);

    localparam int unsigned SRC_CNT_U = SRC_CNT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_FIRE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                             state_q;
    state_t                             state_d;

    logic [OP_WIDTH-1:0]                op_q;
    logic [1:0]                         src_cnt_q;
    logic [SRC_CNT-1:0]                 got_q;
    logic [SRC_CNT*OPERAND_WIDTH-1:0]   opnd_q;
    logic [15:0]                        wait_cnt_q;
    logic [OPERAND_WIDTH-1:0]           rsp_data_q;
    logic                               rsp_err_q;

    logic                               accept;
    logic                               cnt_bad;
    logic                               capture;
    logic [1:0]                         cnt_sel;
    logic [SRC_CNT-1:0]                 needed;
    logic [SRC_CNT-1:0]                 hit;
    logic [SRC_CNT-1:0]                 got_d;
    logic                               all_got;
    logic                               timeout;

    always_comb begin
        accept  = (state_q == S_IDLE) && req_valid_i;
        cnt_bad = (req_src_cnt_i == 2'd0) || ({30'b0, req_src_cnt_i} > SRC_CNT_U);
        // The accept cycle uses the incoming count; COLLECT uses the latched one.
        cnt_sel = accept ? req_src_cnt_i : src_cnt_q;
        capture = (accept && !cnt_bad) || (state_q == S_COLLECT);
        for (int unsigned k = 0; k < SRC_CNT_U; k++) begin
            needed[k] = k < {30'b0, cnt_sel};
            hit[k]    = capture && opnd_valid_i[k] && needed[k];
        end
        got_d   = (accept ? '0 : got_q) | hit;
        all_got = (got_d & needed) == needed;
        timeout = wait_cnt_q == 16'(TIMEOUT - 1);

        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cnt_bad)      state_d = S_RESP;
                    else if (all_got) state_d = S_FIRE;
                    else              state_d = S_COLLECT;
                end
            end
            S_COLLECT: if (all_got) state_d = S_FIRE;
            S_FIRE:    state_d = S_WAIT;
            S_WAIT:    if (lane_done_i || timeout) state_d = S_RESP;
            S_RESP:    if (rsp_ready_i) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            src_cnt_q  <= '0;
            got_q      <= '0;
            opnd_q     <= '0;
            wait_cnt_q <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= req_op_i;
                src_cnt_q <= req_src_cnt_i;
            end
            got_q <= got_d;
            for (int unsigned k = 0; k < SRC_CNT_U; k++) begin
                if (hit[k])
                    opnd_q[k*OPERAND_WIDTH +: OPERAND_WIDTH] <= opnd_i[k*OPERAND_WIDTH +: OPERAND_WIDTH];
                else if (accept)
                    opnd_q[k*OPERAND_WIDTH +: OPERAND_WIDTH] <= '0;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept && cnt_bad) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                S_FIRE: wait_cnt_q <= '0;
                S_WAIT: begin
                    // Completion takes priority over an expiring timeout.
                    if (lane_done_i) begin
                        rsp_data_q <= lane_dout_i;
                        rsp_err_q  <= 1'b0;
                    end else if (timeout) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o    = (state_q == S_IDLE);
    assign lane_start_o   = (state_q == S_FIRE);
    assign rsp_valid_o    = (state_q == S_RESP);
    assign lane_op_o      = op_q;
    assign lane_operand_o = opnd_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_err_o      = rsp_err_q;

endmodule

// File: tb/tb_vpu_lane_seq.sv
// Bench for vpu_lane_seq: directed vector table, reset sequences and
// randomized transactions against a transaction-level reference model.
module tb_vpu_lane_seq;

    localparam int W  = 32;
    localparam int N  = 3;
    localparam int OW = 16;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid_i;
    logic           req_ready_o;
    logic [OW-1:0]  req_op_i;
    logic [1:0]     req_src_cnt_i;
    logic [N*W-1:0] opnd_i;
    logic [N-1:0]   opnd_valid_i;
    logic           lane_start_o;
    logic [OW-1:0]  lane_op_o;
    logic [N*W-1:0] lane_operand_o;
    logic           lane_done_i;
    logic [W-1:0]   lane_dout_i;
    logic           rsp_valid_o;
    logic           rsp_ready_i;
    logic [W-1:0]   rsp_data_o;
    logic           rsp_err_o;

    vpu_lane_seq #(
        .OPERAND_WIDTH (W),
        .SRC_CNT       (N),
        .OP_WIDTH      (OW),
        .TIMEOUT       (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op_i),
        .req_src_cnt_i  (req_src_cnt_i),
        .opnd_i         (opnd_i),
        .opnd_valid_i   (opnd_valid_i),
        .lane_start_o   (lane_start_o),
        .lane_op_o      (lane_op_o),
        .lane_operand_o (lane_operand_o),
        .lane_done_i    (lane_done_i),
        .lane_dout_i    (lane_dout_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_data_o     (rsp_data_o),
        .rsp_err_o      (rsp_err_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int txn_id   = 0;

    // Operand strobe schedule, indexed by cycle relative to the accept cycle.
    logic [N-1:0] sch_v [16];
    logic [W-1:0] sch_d [16][N];

    typedef struct {
        logic [1:0]     cnt;
        logic [OW-1:0]  op;
        logic [23:0]    sched;   // 8 cycles x 3 slot strobes
        int             dd;      // WAIT-cycle index of lane done (>= TO: never)
        logic [W-1:0]   dout;
        int             rr;      // RESP cycles before rsp_ready
        int             e_start;
        int             e_rsp;
        logic           e_err;
        logic [W-1:0]   e_data;
        logic [N*W-1:0] e_opnd;
    } vec_t;

    vec_t tbl [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s txn=%0d act=%h exp=%h", nm, txn_id, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_req_ready"}, 96'(req_ready_o), 96'(1'b1));
        chk({nm, "_start"}, 96'(lane_start_o), 96'(1'b0));
        chk({nm, "_rsp_valid"}, 96'(rsp_valid_o), 96'(1'b0));
        chk({nm, "_rsp_err"}, 96'(rsp_err_o), 96'(1'b0));
        chk({nm, "_rsp_data"}, 96'(rsp_data_o), 96'(0));
        chk({nm, "_lane_op"}, 96'(lane_op_o), 96'(0));
        chk({nm, "_lane_opnd"}, 96'(lane_operand_o), 96'(0));
    endtask

    // Reference: which cycle completes the operand set, which values survive,
    // and where the response lands given the lane's done timing.
    task automatic model(input logic [1:0] cnt, input int dd, input logic [W-1:0] dout,
                         output int e_start, output int e_rsp, output logic e_err,
                         output logic [W-1:0] e_data, output logic [N*W-1:0] e_opnd);
        logic [W-1:0] val [N];
        bit           seen [N];
        int           done_cyc;
        done_cyc = -1;
        e_opnd   = '0;
        for (int k = 0; k < N; k++) begin
            val[k]  = '0;
            seen[k] = 1'b0;
        end
        if (cnt == 0 || int'(cnt) > N) begin
            e_start = -1;
            e_rsp   = 1;
            e_err   = 1'b1;
            e_data  = '0;
            return;
        end
        for (int c = 0; c < 16 && done_cyc < 0; c++) begin
            bit all;
            all = 1'b1;
            for (int k = 0; k < int'(cnt); k++) begin
                if (sch_v[c][k]) begin
                    seen[k] = 1'b1;
                    val[k]  = sch_d[c][k];
                end
                if (!seen[k]) all = 1'b0;
            end
            if (all) done_cyc = c;
        end
        for (int k = 0; k < N; k++) e_opnd[k*W +: W] = val[k];
        e_start = done_cyc + 1;
        if (dd < TO) begin
            e_rsp  = e_start + 1 + dd + 1;
            e_err  = 1'b0;
            e_data = dout;
        end else begin
            e_rsp  = e_start + 1 + TO;
            e_err  = 1'b1;
            e_data = '0;
        end
    endtask

    // Drives one transaction from the current schedule and checks every cycle.
    task automatic run_txn(input logic [OW-1:0] op, input logic [1:0] cnt, input int dd,
                           input logic [W-1:0] dout, input int rr, input int e_start,
                           input int e_rsp, input logic e_err, input logic [W-1:0] e_data,
                           input logic [N*W-1:0] e_opnd);
        int  last;
        int  w_done;
        bit  in_rsp;
        last   = e_rsp + rr + 1;
        w_done = e_start + 1 + dd;
        for (int j = 0; j <= last; j++) begin
            in_rsp = (j >= e_rsp) && (j < last);
            chk("req_ready", 96'(req_ready_o), 96'(j == 0 || j == last));
            chk("lane_start", 96'(lane_start_o), 96'(e_start >= 0 && j == e_start));
            chk("rsp_valid", 96'(rsp_valid_o), 96'(in_rsp));
            if (in_rsp) begin
                chk("rsp_data", 96'(rsp_data_o), 96'(e_data));
                chk("rsp_err", 96'(rsp_err_o), 96'(e_err));
            end
            if (e_start >= 0 && j >= e_start) begin
                chk("lane_op", 96'(lane_op_o), 96'(op));
                chk("lane_opnd", 96'(lane_operand_o), 96'(e_opnd));
            end
            if (j == last) break;

            if (j == 0) begin
                req_valid_i   = 1'b1;
                req_op_i      = op;
                req_src_cnt_i = cnt;
            end else begin
                req_valid_i   = 1'($urandom_range(0, 1));
                req_op_i      = OW'($urandom);
                req_src_cnt_i = 2'($urandom_range(0, 3));
            end
            if (j < 16) begin
                opnd_valid_i = sch_v[j];
                opnd_i       = {sch_d[j][2], sch_d[j][1], sch_d[j][0]};
            end else begin
                opnd_valid_i = 3'($urandom_range(0, 7));
                opnd_i       = {$urandom, $urandom, $urandom};
            end
            lane_done_i = (e_start >= 0 && dd < TO && j == w_done) ||
                          (e_start >= 0 && j <= e_start && $urandom_range(0, 3) == 0);
            lane_dout_i = (j == w_done) ? dout : $urandom;
            rsp_ready_i = (j == e_rsp + rr) || (j < e_rsp && $urandom_range(0, 1) == 1);
            tick();
        end
        req_valid_i  = 1'b0;
        opnd_valid_i = '0;
        lane_done_i  = 1'b0;
        rsp_ready_i  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog txn=%0d act=timeout exp=finish", txn_id);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           e_start;
        int           e_rsp;
        logic         e_err;
        logic [W-1:0] e_data;
        logic [N*W-1:0] e_opnd;
        logic [1:0]   cnt;
        int           dd;
        logic [W-1:0] dout;
        logic [OW-1:0] op;

        rst = 1'b1;  req_valid_i = 1'b0;  req_op_i = '0;  req_src_cnt_i = '0;
        opnd_i = '0; opnd_valid_i = '0;   lane_done_i = 1'b0;  lane_dout_i = '0;
        rsp_ready_i = 1'b0;

        tbl[0] = '{2'd2, 16'h0004, 24'h00000B, 0, 32'h40490FDB, 0, 1, 3, 1'b0, 32'h40490FDB,
                   96'h00000000_20000000_10000000};
        tbl[1] = '{2'd0, 16'h0011, 24'h000007, 0, 32'h55555555, 2, -1, 1, 1'b1, 32'h0, 96'h0};
        tbl[2] = '{2'd1, 16'h0022, 24'h001100, 2, 32'hDEADBEEF, 1, 5, 9, 1'b0, 32'hDEADBEEF,
                   96'h00000000_00000000_10000004};
        tbl[3] = '{2'd3, 16'h0033, 24'h000007, 8, 32'hFFFFFFFF, 0, 1, 10, 1'b1, 32'h0,
                   96'h30000000_20000000_10000000};
        tbl[4] = '{2'd3, 16'h0044, 24'h000007, 7, 32'h12345678, 0, 1, 10, 1'b0, 32'h12345678,
                   96'h30000000_20000000_10000000};
        tbl[5] = '{2'd3, 16'h0055, 24'h818040, 1, 32'hCAFEF00D, 0, 8, 11, 1'b0, 32'hCAFEF00D,
                   96'h30000007_20000005_10000005};
        tbl[6] = '{2'd2, 16'h0066, 24'h00040B, 3, 32'h0BADC0DE, 10, 1, 6, 1'b0, 32'h0BADC0DE,
                   96'h00000000_20000000_10000000};

        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;

        foreach (tbl[t]) begin
            txn_id = t;
            for (int c = 0; c < 16; c++) begin
                sch_v[c] = (c < 8) ? tbl[t].sched[c*3 +: 3] : 3'b000;
                for (int k = 0; k < N; k++) sch_d[c][k] = 32'((k + 1) * 32'h1000_0000 + c);
            end
            run_txn(tbl[t].op, tbl[t].cnt, tbl[t].dd, tbl[t].dout, tbl[t].rr, tbl[t].e_start,
                    tbl[t].e_rsp, tbl[t].e_err, tbl[t].e_data, tbl[t].e_opnd);
        end

        // Reset while waiting on the lane; a late done must not produce a response.
        txn_id        = 100;
        req_valid_i   = 1'b1;
        req_op_i      = 16'h0077;
        req_src_cnt_i = 2'd1;
        opnd_valid_i  = 3'b001;
        opnd_i        = {32'h3, 32'h2, 32'h1};
        tick();
        req_valid_i  = 1'b0;
        opnd_valid_i = '0;
        tick();
        tick();
        chk("wait_req_ready", 96'(req_ready_o), 96'(1'b0));
        chk("wait_lane_op", 96'(lane_op_o), 96'(16'h0077));
        rst           = 1'b1;
        req_valid_i   = 1'b1;
        opnd_valid_i  = 3'b001;
        tick();
        chk_reset_outputs("rst_in_wait");
        rst          = 1'b0;
        req_valid_i  = 1'b0;
        opnd_valid_i = '0;
        lane_done_i  = 1'b1;
        lane_dout_i  = 32'hA5A5A5A5;
        tick();
        lane_done_i = 1'b0;
        chk("post_rst_req_ready", 96'(req_ready_o), 96'(1'b1));
        chk("post_rst_rsp_valid", 96'(rsp_valid_o), 96'(1'b0));
        chk("post_rst_start", 96'(lane_start_o), 96'(1'b0));
        tick();
        chk("post_rst_rsp_valid2", 96'(rsp_valid_o), 96'(1'b0));

        for (int t = 0; t < 150; t++) begin
            txn_id = 1000 + t;
            cnt    = ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            op     = OW'($urandom);
            dout   = $urandom;
            dd     = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 1, TO + 1)
                                                  : $urandom_range(0, 5);
            for (int c = 0; c < 16; c++) begin
                for (int k = 0; k < N; k++) begin
                    sch_v[c][k] = ($urandom_range(0, 2) == 0);
                    sch_d[c][k] = $urandom;
                end
            end
            sch_v[15] = '1;
            model(cnt, dd, dout, e_start, e_rsp, e_err, e_data, e_opnd);
            run_txn(op, cnt, dd, dout, $urandom_range(0, 3), e_start, e_rsp, e_err, e_data, e_opnd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vpu_lane_seq.md
VPU_LANE_SEQ -- requirements
Module: vpu_lane_seq

Interface
REQ-001 Parameter OPERAND_WIDTH, default 32, width of each operand and result.
REQ-002 Parameter SRC_CNT, default 3, number of source operand slots.
REQ-003 Parameter OP_WIDTH, default 16, width of the opaque op-function word forwarded to the lane.
REQ-004 Parameter TIMEOUT, default 255, maximum cycles to wait for lane done (1..65535).
REQ-005 Reset and clock: one clock; reset is synchronous and active-high. Ports are named clk and rst.
REQ-006 clk  in  1  sole clock, all state updates on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 req_valid_i  in  1  new operation request valid.
REQ-009 req_ready_o  out  1  block can accept a request.
REQ-010 req_op_i  in  OP_WIDTH  op-function word for the lane.
REQ-011 req_src_cnt_i  in  2  number of operands needed (1..SRC_CNT).
REQ-012 opnd_i  in  SRC_CNT x OPERAND_WIDTH  per-slot operand data.
REQ-013 opnd_valid_i  in  SRC_CNT  per-slot operand strobe, independent per slot.
REQ-014 lane_start_o  out  1  one-cycle start pulse to the lane.
REQ-015 lane_op_o  out  OP_WIDTH  registered op word, driven to the lane.
REQ-016 lane_operand_o  out  SRC_CNT x OPERAND_WIDTH  registered operands.
REQ-017 lane_done_i / lane_dout_i  in  1 / OPERAND_WIDTH  lane completion and result.
REQ-018 rsp_valid_o / rsp_ready_i  out / in  1 / 1  result handshake.
REQ-019 rsp_data_o / rsp_err_o  out  OPERAND_WIDTH / 1  result and error flag.

Function
REQ-020 FSM states: IDLE, COLLECT, FIRE, WAIT, RESP.
REQ-021 IDLE: req_ready_o=1; other states: req_ready_o=0.
REQ-022 Accept on req_valid_i & req_ready_o: latch op and src_cnt; clear operand registers and got-flags; go to COLLECT.
REQ-023 Operand capture is active in the accept cycle and in COLLECT. opnd_valid_i[k] with k<src_cnt latches opnd_i[k] and sets got[k]. Strobes for k>=src_cnt are ignored, as are all strobes in other states.
REQ-024 A repeated strobe on an already-captured slot overwrites it; the last value wins.
REQ-025 When all needed got-flags are set, counting this cycle's strobes, the next state is FIRE. This holds from the accept cycle or from COLLECT.
REQ-026 src_cnt=0 or src_cnt>SRC_CNT at accept: go directly to RESP with rsp_err_o=1 and rsp_data_o=0; no lane_start_o.
REQ-027 FIRE: lane_start_o=1 for exactly one cycle; clear the wait counter; go to WAIT.
REQ-028 WAIT: lane_done_i is sampled only here. On done: capture lane_dout_i into rsp_data and set err=0; go to RESP.
REQ-029 WAIT: the counter increments each cycle without done. When counter==TIMEOUT-1 and done is still absent: go to RESP with err=1 and data=0.
REQ-030 If done and the timeout condition occur in the same cycle, done wins (err=0).
REQ-031 lane_op_o and lane_operand_o hold stable from the cycle after accept until the next accept. Unused slots read 0.
REQ-032 RESP: rsp_valid_o=1. rsp_data_o and rsp_err_o hold stable until rsp_ready_i; then go to IDLE. rsp_ready_i outside RESP has no effect.
REQ-033 Minimum latency, with all operands present at accept cycle T and done in the first WAIT cycle: FIRE at T+1, WAIT at T+2, rsp_valid_o at T+3.
REQ-034 A new request may be accepted at earliest the cycle after the response handshake.

Reset
REQ-035 rst while high: state=IDLE; req_ready_o=1; lane_start_o=0; rsp_valid_o=0; rsp_err_o=0; rsp_data_o, lane_op_o, lane_operand_o, counter and got-flags all 0.
REQ-036 rst mid-operation, in any state, aborts without issuing a response or a start pulse; the next cycle is IDLE.
REQ-037 Inputs are ignored during the rst cycle.

Verification
REQ-038 Two-operand, both valid at accept, op=0x0004, lane done one cycle after start with dout=0x40490FDB -> single start at T+1, rsp_valid at T+3, data=0x40490FDB, err=0.
REQ-039 Three-operand, slots arriving at T+2, T+5 (slot 0 re-strobed with new value), T+7 -> start at T+8 only; lane_operand_o[0] is the second value.
REQ-040 src_cnt=1, slot-2 strobe during COLLECT -> slot 2 not captured (reads 0); start only after the slot-0 strobe.
REQ-041 TIMEOUT=8, lane never done -> rsp_valid 8 cycles after first WAIT cycle with err=1, data=0. A second run with done arriving on the 8th WAIT cycle -> err=0.
REQ-042 rsp_ready_i held low 10 cycles -> rsp_valid and data stable for all 10 cycles; req_ready_o=0 throughout.
REQ-043 rst asserted in WAIT, then lane_done_i pulses -> no response issued, req_ready_o=1 the cycle after reset.
